// File: rtl/ct_mmu_jtlb_sram_ctrl_pkg.sv
// Shared types and defaults for the jTLB SRAM access controller.
package ct_mmu_jtlb_sram_pkg;

  localparam int JTLB_ADDR_W        = 8;
  localparam int JTLB_DATA_W        = 84;
  localparam int JTLB_RD_STARVE_MAX = 4;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SWEEP = 1'b1
  } sweep_state_e;

endpackage

// File: rtl/ct_mmu_jtlb_sram_ctrl_if.sv
// Requester, sweep-control and SRAM-macro signals of the jTLB SRAM controller.
interface ct_mmu_jtlb_sram_ctrl_if #(
  parameter int ADDR_WIDTH = ct_mmu_jtlb_sram_pkg::JTLB_ADDR_W,
  parameter int DATA_WIDTH = ct_mmu_jtlb_sram_pkg::JTLB_DATA_W
);
  logic                  rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_gnt;
  logic                  rd_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [DATA_WIDTH-1:0] wr_mask;
  logic                  wr_gnt;
  logic                  inv_all_req;
  logic                  inv_busy;
  logic                  inv_done;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;
  logic [DATA_WIDTH-1:0] sram_q;

  modport slave (
    input  rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, inv_all_req, sram_q,
    output rd_gnt, rd_vld, rd_data, wr_gnt, inv_busy, inv_done,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );

  modport master (
    output rd_req, rd_addr, wr_req, wr_addr, wr_data, wr_mask, inv_all_req, sram_q,
    input  rd_gnt, rd_vld, rd_data, wr_gnt, inv_busy, inv_done,
           sram_a, sram_cen, sram_gwen, sram_wen, sram_d
  );
endinterface

// File: rtl/ct_mmu_jtlb_sram_ctrl_sweep.sv
// Invalidate-all sweep: walks every jTLB index once, then pulses inv_done.
//   state    | meaning
//   ST_IDLE  | array port free for lookup/refill arbitration
//   ST_SWEEP | one zero-write per cycle at sweep_cnt_q
module ct_mmu_jtlb_sram_sweep
  import ct_mmu_jtlb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH = JTLB_ADDR_W
) (
  input  logic                  clk_i,
  input  logic                  rst_b_i,
  input  logic                  inv_all_req_i,
  output logic                  sweep_active_o,
  output logic [ADDR_WIDTH-1:0] sweep_addr_o,
  output logic                  inv_busy_o,
  output logic                  inv_done_o
);

  sweep_state_e          state_q;
  logic [ADDR_WIDTH-1:0] sweep_cnt_q;
  logic                  inv_done_q;

  // Requests arriving mid-sweep are dropped; a level held past done restarts.
  always_ff @(posedge clk_i or negedge rst_b_i) begin
    if (!rst_b_i) begin
      state_q     <= ST_IDLE;
      sweep_cnt_q <= '0;
      inv_done_q  <= 1'b0;
    end else begin
      inv_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (inv_all_req_i) state_q <= ST_SWEEP;
        end
        ST_SWEEP: begin
          sweep_cnt_q <= sweep_cnt_q + 1'b1;
          if (&sweep_cnt_q) begin
            state_q    <= ST_IDLE;
            inv_done_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign sweep_active_o = (state_q == ST_SWEEP);
  assign inv_busy_o     = (state_q == ST_SWEEP);
  assign sweep_addr_o   = sweep_cnt_q;
  assign inv_done_o     = inv_done_q;

endmodule

// File: rtl/ct_mmu_jtlb_sram_ctrl.sv
// jTLB SRAM port controller: arbitrates lookup reads against refill writes,
// hands the port to the invalidate sweep, and drives the macro's active-low pins.
module ct_mmu_jtlb_sram_ctrl
  import ct_mmu_jtlb_sram_pkg::*;
#(
  parameter int ADDR_WIDTH    = JTLB_ADDR_W,
  parameter int DATA_WIDTH    = JTLB_DATA_W,
  parameter int RD_STARVE_MAX = JTLB_RD_STARVE_MAX
) (
  input  logic                     forever_cpuclk,
  input  logic                     cpurst_b,
  ct_mmu_jtlb_sram_ctrl_if.slave   bus
);

  localparam logic [3:0] STARVE_LIM = 4'(RD_STARVE_MAX);

  logic                  sweep_active;
  logic [ADDR_WIDTH-1:0] sweep_addr;
  logic                  inv_busy;
  logic                  inv_done;
  logic                  rd_win;
  logic                  rd_gnt;
  logic                  wr_gnt;
  logic [3:0]            rd_wait_cnt_q, rd_wait_cnt_d;
  logic                  rd_vld_q;
  logic [ADDR_WIDTH-1:0] sram_a;
  logic                  sram_cen;
  logic                  sram_gwen;
  logic [DATA_WIDTH-1:0] sram_wen;
  logic [DATA_WIDTH-1:0] sram_d;

  ct_mmu_jtlb_sram_sweep #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sweep (
    .clk_i          (forever_cpuclk),
    .rst_b_i        (cpurst_b),
    .inv_all_req_i  (bus.inv_all_req),
    .sweep_active_o (sweep_active),
    .sweep_addr_o   (sweep_addr),
    .inv_busy_o     (inv_busy),
    .inv_done_o     (inv_done)
  );

  // Refill normally wins; a lookup starved for RD_STARVE_MAX cycles takes the port.
  always_comb begin
    rd_win        = bus.rd_req && (!bus.wr_req || (rd_wait_cnt_q == STARVE_LIM));
    rd_gnt        = !sweep_active && rd_win;
    wr_gnt        = !sweep_active && bus.wr_req && !rd_win;
    rd_wait_cnt_d = rd_wait_cnt_q;
    if (!sweep_active) begin
      if (!bus.rd_req || rd_gnt) begin
        rd_wait_cnt_d = '0;
      end else if (rd_wait_cnt_q != STARVE_LIM) begin
        rd_wait_cnt_d = rd_wait_cnt_q + 4'd1;
      end
    end
  end

  always_comb begin
    sram_a    = '0;
    sram_cen  = 1'b1;
    sram_gwen = 1'b1;
    sram_wen  = '1;
    sram_d    = '0;
    if (sweep_active) begin
      sram_a    = sweep_addr;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = '0;
    end else if (wr_gnt) begin
      sram_a    = bus.wr_addr;
      sram_cen  = 1'b0;
      sram_gwen = 1'b0;
      sram_wen  = ~bus.wr_mask;
      sram_d    = bus.wr_data;
    end else if (rd_gnt) begin
      sram_a    = bus.rd_addr;
      sram_cen  = 1'b0;
    end
  end

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      rd_wait_cnt_q <= '0;
      rd_vld_q      <= 1'b0;
    end else begin
      rd_wait_cnt_q <= rd_wait_cnt_d;
      rd_vld_q      <= rd_gnt;
    end
  end

  assign bus.rd_gnt    = rd_gnt;
  assign bus.wr_gnt    = wr_gnt;
  assign bus.rd_vld    = rd_vld_q;
  assign bus.rd_data   = rd_vld_q ? bus.sram_q : '0;
  assign bus.inv_busy  = inv_busy;
  assign bus.inv_done  = inv_done;
  assign bus.sram_a    = sram_a;
  assign bus.sram_cen  = sram_cen;
  assign bus.sram_gwen = sram_gwen;
  assign bus.sram_wen  = sram_wen;
  assign bus.sram_d    = sram_d;

endmodule

// File: tb/tb_ct_mmu_jtlb_sram_ctrl.sv
// Bench for ct_mmu_jtlb_sram_ctrl: directed scenarios plus random traffic,
// checked against a cycle-level reference of the array contents and port rules.
module tb_ct_mmu_jtlb_sram_ctrl;
  localparam int AW   = 8;
  localparam int DW   = 84;
  localparam int NW   = 1 << AW;
  localparam int SMAX = 4;
  localparam logic [DW-1:0] ALL1   = '1;
  localparam logic [DW-1:0] MASK_F = 84'hF;
  localparam logic [DW-1:0] DATA_A = 84'hABC_DEF0_1234_5678_9ABC_DE;
  localparam logic [DW-1:0] DATA_B = 84'h123;

  logic clk = 1'b0;
  logic rst_b = 1'b0;
  logic load = 1'b0;
  int   total = 0;
  int   bad = 0;

  ct_mmu_jtlb_sram_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) ifc ();

  ct_mmu_jtlb_sram_ctrl #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_STARVE_MAX(SMAX)) dut (
    .forever_cpuclk (clk),
    .cpurst_b       (rst_b),
    .bus            (ifc)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] sram_mem [NW];
  logic [DW-1:0] ref_mem  [NW];

  // Behavioural macro: active-low pins, registered read port.
  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < NW; i++) sram_mem[i] <= ref_mem[i];
    end else if (!ifc.sram_cen) begin
      if (!ifc.sram_gwen)
        sram_mem[ifc.sram_a] <= (sram_mem[ifc.sram_a] & ifc.sram_wen) | (ifc.sram_d & ~ifc.sram_wen);
      else
        ifc.sram_q <= sram_mem[ifc.sram_a];
    end
  end

  // Reference state
  bit            m_sweep, m_done, m_vld;
  int            m_idx, m_starve;
  logic [DW-1:0] m_rdat;

  logic          last_rd_gnt, last_wr_gnt, last_busy, last_done, last_e_rg, last_e_wg;
  logic [DW-1:0] last_rd_data;
  logic [AW-1:0] last_sram_a;

  function automatic logic [DW-1:0] rnd_word();
    logic [95:0] t;
    t = {$urandom(), $urandom(), $urandom()};
    return t[DW-1:0];
  endfunction

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_in(input logic rq, input logic [AW-1:0] ra, input logic wq,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                        input logic [DW-1:0] wm, input logic inv);
    ifc.rd_req = rq; ifc.rd_addr = ra; ifc.wr_req = wq; ifc.wr_addr = wa;
    ifc.wr_data = wd; ifc.wr_mask = wm; ifc.inv_all_req = inv;
  endtask

  // Called just after a falling edge with inputs set; checks, advances the model, ends at next falling edge.
  task automatic cycle();
    logic          e_rg, e_wg, e_cen, e_gwen;
    logic [AW-1:0] e_a;
    logic [DW-1:0] e_wen, e_d, nrdat;
    bit            rw, ndone;
    #1;
    e_rg = 0; e_wg = 0; e_cen = 1; e_gwen = 1; e_a = '0; e_wen = ALL1; e_d = '0;
    if (m_sweep) begin
      e_cen = 0; e_gwen = 0; e_a = AW'(m_idx); e_wen = '0;
    end else begin
      rw   = ifc.rd_req && (!ifc.wr_req || m_starve >= SMAX);
      e_rg = rw;
      e_wg = ifc.wr_req && !rw;
      if (e_wg) begin
        e_cen = 0; e_gwen = 0; e_a = ifc.wr_addr; e_wen = ~ifc.wr_mask; e_d = ifc.wr_data;
      end else if (e_rg) begin
        e_cen = 0; e_a = ifc.rd_addr;
      end
    end
    chk("rd_gnt", DW'(ifc.rd_gnt), DW'(e_rg));
    chk("wr_gnt", DW'(ifc.wr_gnt), DW'(e_wg));
    chk("sram_cen", DW'(ifc.sram_cen), DW'(e_cen));
    chk("sram_gwen", DW'(ifc.sram_gwen), DW'(e_gwen));
    chk("sram_wen", ifc.sram_wen, e_wen);
    chk("sram_a", DW'(ifc.sram_a), DW'(e_a));
    if (!(e_rg && !e_wg && !m_sweep)) chk("sram_d", ifc.sram_d, e_d);
    chk("rd_vld", DW'(ifc.rd_vld), DW'(m_vld));
    chk("rd_data", ifc.rd_data, m_vld ? m_rdat : '0);
    chk("inv_busy", DW'(ifc.inv_busy), DW'(m_sweep));
    chk("inv_done", DW'(ifc.inv_done), DW'(m_done));
    last_rd_gnt = ifc.rd_gnt; last_wr_gnt = ifc.wr_gnt; last_busy = ifc.inv_busy;
    last_done = ifc.inv_done; last_rd_data = ifc.rd_data; last_sram_a = ifc.sram_a;
    last_e_rg = e_rg; last_e_wg = e_wg;

    nrdat = ref_mem[ifc.rd_addr];
    if (e_wg) ref_mem[ifc.wr_addr] = (ref_mem[ifc.wr_addr] & ~ifc.wr_mask) | (ifc.wr_data & ifc.wr_mask);
    ndone = 0;
    if (m_sweep) begin
      ref_mem[m_idx] = '0;
      m_idx++;
      if (m_idx == NW) begin m_sweep = 0; m_idx = 0; ndone = 1; end
    end else begin
      if (ifc.inv_all_req) m_sweep = 1;
      if (!ifc.rd_req || e_rg) m_starve = 0;
      else if (m_starve < SMAX) m_starve++;
    end
    m_vld = e_rg; m_rdat = nrdat; m_done = ndone;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    set_in(0, '0, 0, '0, '0, '0, 0);
    rst_b = 1'b0;
    #1;
    chk("rst_busy", DW'(ifc.inv_busy), '0);
    chk("rst_done", DW'(ifc.inv_done), '0);
    chk("rst_vld", DW'(ifc.rd_vld), '0);
    chk("rst_cen", DW'(ifc.sram_cen), DW'(1'b1));
    m_sweep = 0; m_idx = 0; m_done = 0; m_starve = 0; m_vld = 0; m_rdat = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_b = 1'b1;
  endtask

  task automatic rd_check(input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    set_in(1, a, 0, '0, '0, '0, 0);
    cycle();
    set_in(0, '0, 0, '0, '0, '0, 0);
    cycle();
    chk(tag, last_rd_data, exp);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, first, busy_n, done_n, done_pos, g;
    bit rd_pend, wr_pend;
    logic [AW-1:0] ra, wa;
    logic [DW-1:0] wd, wm;

    set_in(0, '0, 0, '0, '0, '0, 0);
    for (int i = 0; i < NW; i++) ref_mem[i] = rnd_word();
    @(negedge clk);
    load = 1'b1;
    @(posedge clk);
    @(negedge clk);
    load = 1'b0;
    do_reset();
    repeat (10) cycle();

    // Full write then read-back, then a nibble-masked rewrite
    set_in(0, '0, 1, 8'h12, DATA_A, ALL1, 0);
    cycle();
    chk("dir_wr_gnt", DW'(last_wr_gnt), DW'(1'b1));
    rd_check(8'h12, DATA_A, "dir_rd_full");
    set_in(0, '0, 1, 8'h12, DATA_B, MASK_F, 0);
    cycle();
    rd_check(8'h12, (DATA_A & ~MASK_F) | (DATA_B & MASK_F), "dir_rd_mask");
    set_in(0, '0, 1, 8'h12, DATA_B, '0, 0);
    cycle();
    chk("zero_mask_gnt", DW'(last_wr_gnt), DW'(1'b1));
    rd_check(8'h12, (DATA_A & ~MASK_F) | (DATA_B & MASK_F), "dir_rd_zmask");

    // Starvation under continuous refill
    n = 0; first = -1;
    set_in(1, 8'h12, 1, 8'h40, DATA_B, ALL1, 0);
    for (int i = 0; i < 15; i++) begin
      cycle();
      if (last_rd_gnt) begin n++; if (first < 0) first = i; end
    end
    chk("starve_first", DW'(first), DW'(SMAX));
    chk("starve_cnt", DW'(n), DW'(3));
    set_in(0, '0, 0, '0, '0, '0, 0);
    cycle();

    // Idle sweep
    set_in(0, '0, 0, '0, '0, '0, 1);
    cycle();
    ifc.inv_all_req = 1'b0;
    busy_n = 0; done_n = 0; done_pos = -1;
    for (int i = 0; i < 270; i++) begin
      cycle();
      if (last_busy) busy_n++;
      if (last_done) begin done_n++; done_pos = i; end
    end
    chk("sweep_busy_len", DW'(busy_n), DW'(NW));
    chk("sweep_done_cnt", DW'(done_n), DW'(1));
    chk("sweep_done_pos", DW'(done_pos), DW'(NW));
    rd_check(8'h00, '0, "sweep_rd_00");
    rd_check(8'h80, '0, "sweep_rd_80");
    rd_check(8'hFF, '0, "sweep_rd_ff");

    // Sweep with both requesters held
    wd = rnd_word();
    set_in(1, 8'h33, 1, 8'h44, wd, ALL1, 1);
    cycle();
    ifc.inv_all_req = 1'b0;
    g = 0;
    for (int i = 0; i < NW; i++) begin
      cycle();
      if (last_rd_gnt || last_wr_gnt) g++;
    end
    chk("sweep_hold_gnts", DW'(g), '0);
    cycle();
    chk("post_sweep_wr", DW'(last_wr_gnt), DW'(1'b1));
    ifc.wr_req = 1'b0;
    cycle();
    chk("post_sweep_rd", DW'(last_rd_gnt), DW'(1'b1));
    set_in(0, '0, 0, '0, '0, '0, 0);
    cycle();
    rd_check(8'h44, wd, "post_sweep_data");

    // Reset in the middle of a sweep, then restart
    set_in(0, '0, 0, '0, '0, '0, 1);
    cycle();
    ifc.inv_all_req = 1'b0;
    repeat (100) cycle();
    do_reset();
    repeat (3) cycle();
    set_in(0, '0, 0, '0, '0, '0, 1);
    cycle();
    ifc.inv_all_req = 1'b0;
    cycle();
    chk("restart_a", DW'(last_sram_a), '0);
    repeat (NW + 2) cycle();

    // Random traffic
    rd_pend = 0; wr_pend = 0; ra = '0; wa = '0; wd = '0; wm = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!rd_pend && ($urandom_range(0, 2) == 0)) begin
        rd_pend = 1;
        ra = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom());
      end
      if (!wr_pend && ($urandom_range(0, 2) == 0)) begin
        wr_pend = 1;
        wa = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 15)) : AW'($urandom());
        wd = rnd_word();
        case ($urandom_range(0, 3))
          0: wm = ALL1;
          1: wm = '0;
          default: wm = rnd_word();
        endcase
      end
      set_in(rd_pend, ra, wr_pend, wa, wd, wm, ($urandom_range(0, 599) == 0));
      cycle();
      if (last_e_rg) rd_pend = 0;
      if (last_e_wg) wr_pend = 0;
    end
    set_in(0, '0, 0, '0, '0, '0, 0);
    repeat (NW + 4) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
